// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
//
// Two-master, one-slave Wishbone B4 arbiter for the shared SRAM bus.
//   master 0 : host / SPI loader (dictionary and bit-vector tables)
//   master 1 : Levenshtein search engine
//   slave    : SRAM controller
//
// The grant is held for the whole cycle (cyc high), so incremental bursts
// are never split. On release the grant passes directly to the other master
// if it is requesting, which prevents starvation. From idle, master 0 wins
// a simultaneous request.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   mN_cyc/stb/we/adr/dat/cti/bte_i    master N request side (N = 0, 1)
//   mN_ack/err/rty_o, mN_dat_o         terminations and read data to master N
//   s_cyc/stb/we/adr/dat/cti/bte_o     slave request side
//   s_ack/err/rty_i, s_dat_i           slave terminations and read data
//   gnt_o                              one-hot owner, 00 = idle
//   timeout_o                          sticky watchdog flag (reset clears)
//
// Optional feature, macro WB_ARB_TIMEOUT_EN:
//   builds a 16-bit stall watchdog. After TIMEOUT_CYCLES stalled strobe
//   cycles the owner receives a one-cycle err, s_cyc_o/s_stb_o are forced
//   low for that cycle and timeout_o is set. Without the macro no counter
//   exists, timeout_o is 0 and a stalled slave stalls the owner forever.
// ---------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 24,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [7:0]            m0_dat_i,
  input  logic [2:0]            m0_cti_i,
  input  logic [1:0]            m0_bte_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [7:0]            m0_dat_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [7:0]            m1_dat_i,
  input  logic [2:0]            m1_cti_i,
  input  logic [1:0]            m1_bte_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [7:0]            m1_dat_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [7:0]            s_dat_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [7:0]            s_dat_i,

  output logic [1:0]            gnt_o,
  output logic                  timeout_o
);

  // Parameter range check at elaboration time.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } owner_e;

  owner_e owner_q, owner_d;

  // Selected owner request, zero when idle.
  logic                  own_cyc;
  logic                  own_stb;
  logic                  own_we;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [7:0]            own_dat;
  logic [2:0]            own_cti;
  logic [1:0]            own_bte;

  logic                  slv_term;
  logic                  timeout_hit;

  assign slv_term = s_ack_i | s_err_i | s_rty_i;

  // -------------------------------------------------------------------------
  // Owner register
  // -------------------------------------------------------------------------
  always_comb begin
    owner_d = owner_q;
    unique case (owner_q)
      IDLE: begin
        if (m0_cyc_i)      owner_d = OWN0;
        else if (m1_cyc_i) owner_d = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) owner_d = m1_cyc_i ? OWN1 : IDLE;
      end
      OWN1: begin
        if (!m1_cyc_i) owner_d = m0_cyc_i ? OWN0 : IDLE;
      end
      default: owner_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) owner_q <= IDLE;
    else         owner_q <= owner_d;
  end

  always_comb begin
    gnt_o = '0;
    gnt_o[0] = (owner_q == OWN0);
    gnt_o[1] = (owner_q == OWN1);
  end

  // -------------------------------------------------------------------------
  // Combinational data path, steered by the owner register only
  // -------------------------------------------------------------------------
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_cti = '0;
    own_bte = '0;
    unique case (owner_q)
      OWN0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
        own_cti = m0_cti_i;
        own_bte = m0_bte_i;
      end
      OWN1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        own_we  = m1_we_i;
        own_adr = m1_adr_i;
        own_dat = m1_dat_i;
        own_cti = m1_cti_i;
        own_bte = m1_bte_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    // A watchdog expiry withdraws the cycle from the slave for one clock.
    s_cyc_o = own_cyc & ~timeout_hit;
    s_stb_o = own_stb & ~timeout_hit;
    s_we_o  = own_we;
    s_adr_o = own_adr;
    s_dat_o = own_dat;
    s_cti_o = own_cti;
    s_bte_o = own_bte;
  end

  always_comb begin
    m0_ack_o = (owner_q == OWN0) & s_ack_i;
    m0_err_o = (owner_q == OWN0) & (s_err_i | timeout_hit);
    m0_rty_o = (owner_q == OWN0) & s_rty_i;
    m1_ack_o = (owner_q == OWN1) & s_ack_i;
    m1_err_o = (owner_q == OWN1) & (s_err_i | timeout_hit);
    m1_rty_o = (owner_q == OWN1) & s_rty_i;
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
  end

  // -------------------------------------------------------------------------
  // Stall watchdog
  // -------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog_q, wdog_d;
  logic        timeout_q, timeout_d;
  logic        stalled;

  // wdog_q counts stalled cycles already seen, so the expiry fires in the
  // TIMEOUT_CYCLES-th stalled cycle itself.
  assign stalled = own_cyc & own_stb & ~slv_term;

  always_comb begin
    wdog_d      = wdog_q;
    timeout_d   = timeout_q;
    timeout_hit = 1'b0;
    if (stalled && wdog_q == WDOG_LAST) begin
      timeout_hit = 1'b1;
      timeout_d   = 1'b1;
    end
    if (owner_q == IDLE || owner_d != owner_q || slv_term || timeout_hit) begin
      wdog_d = '0;
    end else if (stalled) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

endmodule
